frame_dma_burst_reader: RTL and testbench

//  Avalon-MM read master that fetches one video frame from DDR and fills the write side of a simple_dcfifo.

---
 rtl/frame_dma_pkg.sv | 21 ++
 rtl/frame_dma_credit.sv | 46 ++++
 rtl/frame_dma_burst_reader.sv | 153 +++++++++++++++
 tb/tb_frame_dma_burst_reader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_dma_pkg.sv
// Shared types and helpers for the frame DMA burst reader.
package frame_dma_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BURST_LEN  = 16;
  localparam int BURST_BYTES    = DEF_BURST_LEN * DEF_DATA_WIDTH / 8;
  localparam int BC_W           = $clog2(DEF_BURST_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    REQ   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  function automatic logic [31:0] min_bc(input logic [31:0] req_left,
                                         input logic [31:0] burst_len);
    return (req_left < burst_len) ? req_left : burst_len;
  endfunction

endpackage

// File: rtl/frame_dma_credit.sv
// Outstanding-word counter and FIFO credit check for the frame DMA reader.
module frame_dma_credit
  import frame_dma_pkg::*;
#(
  parameter int FIFO_AW = 9,
  parameter int BC_LW   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BC_LW-1:0]   bc,
  input  logic               accept,
  input  logic               rdvalid,
  input  logic [FIFO_AW-1:0] wrusedw,
  output logic               ok,
  output logic [FIFO_AW:0]   pending
);

  localparam logic [FIFO_AW:0]   P_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW+1:0] LIMIT = (FIFO_AW+2)'((1 << FIFO_AW) - 1);

  logic [FIFO_AW:0]   pending_q;
  logic [FIFO_AW:0]   pending_d;
  logic [FIFO_AW+1:0] need;

  // One extra bit over the FIFO level so wrusedw + pending + bc cannot wrap.
  assign need    = {2'b00, wrusedw} + {1'b0, pending_q} + (FIFO_AW+2)'(bc);
  assign ok      = (need <= LIMIT);
  assign pending = pending_q;

  always_comb begin
    pending_d = pending_q;
    case ({accept, rdvalid})
      2'b11:   pending_d = pending_q + (FIFO_AW+1)'(bc) - P_ONE;
      2'b10:   pending_d = pending_q + (FIFO_AW+1)'(bc);
      // A stray beat with nothing outstanding must not underflow the count.
      2'b01:   pending_d = (pending_q == '0) ? pending_q : pending_q - P_ONE;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

endmodule

// File: rtl/frame_dma_burst_reader.sv
// Avalon-MM burst read master filling a dual-clock FIFO with one frame per start.
// Optional FRAME_DMA_PERF_EN adds a saturating stall counter output perf_stall_cnt.
module frame_dma_burst_reader
  import frame_dma_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AVM_AW     = 32,
  parameter int FIFO_AW    = 9,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int LEN_W      = 24,
  localparam int BC_LW     = $clog2(BURST_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [AVM_AW-1:0]     frame_base,
  input  logic [LEN_W-1:0]      frame_words,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [AVM_AW-1:0]     avm_address,
  output logic                  avm_read,
  output logic [BC_LW-1:0]      avm_burstcount,
  input  logic                  avm_waitrequest,
  input  logic [DATA_WIDTH-1:0] avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_wrreq,
  input  logic [FIFO_AW-1:0]    fifo_wrusedw,
  input  logic                  fifo_wrfull,
`ifdef FRAME_DMA_PERF_EN
  output logic [31:0]           perf_stall_cnt,
`endif
  output state_e                dbg_state
);

  localparam logic [FIFO_AW:0]  PEND_ONE   = (FIFO_AW+1)'(1);
  localparam logic [AVM_AW-1:0] WORD_BYTES = AVM_AW'(DATA_WIDTH / 8);

  state_e              state_q;
  logic [AVM_AW-1:0]   addr_q;
  logic [LEN_W-1:0]    req_left_q;
  logic [BC_LW-1:0]    bc_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;
  logic                read_q;

  logic [BC_LW-1:0]    bc_d;
  logic [BC_LW-1:0]    credit_bc;
  logic                accept;
  logic                credit_ok;
  logic [FIFO_AW:0]    pending;
  logic                drained;

  assign bc_d      = BC_LW'(min_bc(32'(req_left_q), 32'(BURST_LEN)));
  assign credit_bc = (state_q == REQ) ? bc_q : bc_d;
  assign accept    = read_q && !avm_waitrequest;
  // Lets done follow the final beat by one cycle instead of two.
  assign drained   = (pending == '0) || ((pending == PEND_ONE) && avm_readdatavalid);

  frame_dma_credit #(
    .FIFO_AW (FIFO_AW),
    .BC_LW   (BC_LW)
  ) u_credit (
    .clk     (clk),
    .reset   (reset),
    .bc      (credit_bc),
    .accept  (accept),
    .rdvalid (avm_readdatavalid),
    .wrusedw (fifo_wrusedw),
    .ok      (credit_ok),
    .pending (pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      req_left_q <= '0;
      bc_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      read_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fifo_wrfull && avm_readdatavalid) ovf_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q     <= frame_base;
            req_left_q <= frame_words;
            busy_q     <= 1'b1;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          if (req_left_q == '0) begin
            state_q <= DRAIN;
          end else if (credit_ok) begin
            bc_q    <= bc_d;
            read_q  <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (!avm_waitrequest) begin
            read_q     <= 1'b0;
            addr_q     <= addr_q + AVM_AW'(bc_q) * WORD_BYTES;
            req_left_q <= req_left_q - LEN_W'(bc_q);
            state_q    <= CHECK;
          end
        end
        DRAIN: begin
          if (drained) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FRAME_DMA_PERF_EN
  logic [31:0] perf_q;
  logic        stall;

  assign stall = ((state_q == CHECK) && (req_left_q != '0) && !credit_ok) ||
                 ((state_q == REQ) && avm_waitrequest);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                perf_q <= '0;
    else if ((state_q == IDLE) && start)      perf_q <= '0;
    else if (stall && (perf_q != 32'hFFFF_FFFF)) perf_q <= perf_q + 32'd1;
  end

  assign perf_stall_cnt = perf_q;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = ovf_q;
  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_burstcount = bc_q;
  assign fifo_data      = avm_readdata;
  assign fifo_wrreq     = avm_readdatavalid;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_frame_dma_burst_reader.sv
// Bench for frame_dma_burst_reader: Avalon slave model, burst and data scoreboards.
module tb_frame_dma_burst_reader;
  import frame_dma_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int FAW = 9;
  localparam int BL  = 16;
  localparam int LW  = 24;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            start;
  logic [AW-1:0]   frame_base;
  logic [LW-1:0]   frame_words;
  logic            busy, done, overflow;
  logic [AW-1:0]   avm_address;
  logic            avm_read;
  logic [BC_W-1:0] avm_burstcount;
  logic            avm_waitrequest;
  logic [DW-1:0]   avm_readdata;
  logic            avm_readdatavalid;
  logic [DW-1:0]   fifo_data;
  logic            fifo_wrreq;
  logic [FAW-1:0]  fifo_wrusedw;
  logic            fifo_wrfull;
  state_e          dbg_state;
`ifdef FRAME_DMA_PERF_EN
  logic [31:0]     perf_stall_cnt;
`endif

  frame_dma_burst_reader dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .frame_base        (frame_base),
    .frame_words       (frame_words),
    .busy              (busy),
    .done              (done),
    .overflow          (overflow),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .fifo_data         (fifo_data),
    .fifo_wrreq        (fifo_wrreq),
    .fifo_wrusedw      (fifo_wrusedw),
    .fifo_wrfull       (fifo_wrfull),
`ifdef FRAME_DMA_PERF_EN
    .perf_stall_cnt    (perf_stall_cnt),
`endif
    .dbg_state         (dbg_state)
  );

  typedef struct {
    logic [31:0] data;
    int          ready;
  } rd_item_t;

  // scoreboard
  logic [DW-1:0]      exp_q[$];
  logic [AW+BC_W-1:0] exp_burst_q[$];
  rd_item_t           rd_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, last_rd_cyc = 0, wr_cnt = 0, read_seen = 0;
  int burst_cnt = 0, wait_idx = -1, wait_left = 0, pend_model = 0, last_ready = 0;
  int frame_wr0 = 0, start_cyc = 0;
  logic exp_ovf = 1'b0;
  logic stray_pend = 1'b0, stray_live = 1'b0;
  logic hold_chk = 1'b0;
  logic [AW-1:0]   hold_addr;
  logic [BC_W-1:0] hold_bc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  // One clock: drive slave inputs just after the edge, observe at the falling edge.
  task automatic tick();
    rd_item_t it;
    logic [AW+BC_W-1:0] eb;
    @(posedge clk);
    cyc++;
    #1;
    avm_waitrequest = (burst_cnt == wait_idx) && (wait_left > 0);
    if (stray_pend) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'hDEAD_BEEF;
      stray_pend        = 1'b0;
      stray_live        = 1'b1;
    end else if (rd_q.size() > 0 && rd_q[0].ready <= cyc) begin
      it                = rd_q.pop_front();
      avm_readdatavalid = 1'b1;
      avm_readdata      = it.data;
      stray_live        = 1'b0;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      stray_live        = 1'b0;
    end
    @(negedge clk);
    if (reset) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_read", 64'(avm_read), 64'd1);
        chk("hold_addr", 64'(avm_address), 64'(hold_addr));
        chk("hold_bc", 64'(avm_burstcount), 64'(hold_bc));
      end
      hold_chk  = avm_read && avm_waitrequest;
      hold_addr = avm_address;
      hold_bc   = avm_burstcount;
      if (avm_read) read_seen++;
      if (avm_read && avm_waitrequest && wait_left > 0) wait_left--;
      if (avm_read && !avm_waitrequest) begin
        chk("credit", 64'((int'(fifo_wrusedw) + pend_model + int'(avm_burstcount)) <= 511), 64'd1);
        if (exp_burst_q.size() == 0) begin
          chk("extra_burst", 64'd1, 64'd0);
        end else begin
          eb = exp_burst_q.pop_front();
          chk("burst_addr", 64'(avm_address), 64'(eb[AW+BC_W-1:BC_W]));
          chk("burst_bc", 64'(avm_burstcount), 64'(eb[BC_W-1:0]));
        end
        for (int i = 0; i < int'(avm_burstcount); i++) begin
          it.data    = word_of(avm_address + 32'(4 * i));
          last_ready = (last_ready + 1 > cyc + 2) ? last_ready + 1 : cyc + 2;
          it.ready   = last_ready;
          rd_q.push_back(it);
        end
        pend_model += int'(avm_burstcount);
        burst_cnt++;
      end
      if (fifo_wrreq) begin
        wr_cnt++;
        last_rd_cyc = cyc;
        if (stray_live) chk("stray_fwd", 64'(fifo_data), 64'hDEAD_BEEF);
        else if (exp_q.size() > 0) chk("fifo_data", 64'(fifo_data), 64'(exp_q.pop_front()));
        if (pend_model > 0) pend_model--;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic start_frame(input logic [31:0] base, input int words);
    logic [31:0] a;
    int left;
    int b;
    a    = base;
    left = words;
    for (int i = 0; i < words; i++) exp_q.push_back(word_of(base + 32'(4 * i)));
    while (left > 0) begin
      b = (left < BL) ? left : BL;
      exp_burst_q.push_back({a, BC_W'(b)});
      a    += 32'(b * (DW / 8));
      left -= b;
    end
    frame_wr0   = wr_cnt;
    burst_cnt   = 0;
    frame_base  = base;
    frame_words = LW'(words);
    start       = 1'b1;
    start_cyc   = cyc;
    tick();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int words, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 64'(n < budget), 64'd1);
    if (words > 0) chk({tag, "_done_lat"}, 64'(done_cyc), 64'(last_rd_cyc + 1));
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    chk({tag, "_words"}, 64'(wr_cnt - frame_wr0), 64'(words));
    chk({tag, "_data_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_burst_left"}, 64'(exp_burst_q.size()), 64'd0);
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    repeat (4) tick();
    chk({tag, "_one_done"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    reset             = 1'b1;
    start             = 1'b0;
    frame_base        = '0;
    frame_words       = '0;
    fifo_wrusedw      = '0;
    fifo_wrfull       = 1'b0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_read", 64'(avm_read), 64'd0);
    chk("rst_addr", 64'(avm_address), 64'd0);
    chk("rst_bc", 64'(avm_burstcount), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    reset = 1'b0;
    repeat (2) tick();

    // 64 words in four full bursts; a start during the frame must be ignored
    start_frame(32'h1000_0000, 64);
    repeat (4) tick();
    frame_base  = 32'hFFFF_0000;
    frame_words = LW'(8);
    start       = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t1", 64, 2000);

    // 37 words, address wraps past the top of the space
    start_frame(32'hFFFF_FFC0, 37);
    wait_done("t2", 37, 2000);

    // credit blocked by a nearly full FIFO
    fifo_wrusedw = FAW'(500);
    r0 = read_seen;
    start_frame(32'h0000_4000, 32);
    repeat (30) tick();
    chk("t3_blocked", 64'(read_seen - r0), 64'd0);
    fifo_wrusedw = FAW'(495);
    wait_done("t3", 32, 3000);
    fifo_wrusedw = '0;

    // waitrequest held for 10 cycles on the second burst
    wait_idx  = 1;
    wait_left = 10;
    start_frame(32'h0002_0000, 64);
    wait_done("t4", 64, 2000);
    chk("t4_wait_used", 64'(wait_left), 64'd0);
    wait_idx = -1;

    // zero-length frame, plus start while busy
    r0 = read_seen;
    start_frame(32'h3000_0000, 0);
    frame_words = LW'(5);
    start       = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5", 0, 50);
    chk("t5_latency", 64'(done_cyc - start_cyc), 64'd3);
    chk("t5_no_read", 64'(read_seen - r0), 64'd0);

    // stray beat while idle and FIFO full: forwarded, overflow sticks, no underflow
    fifo_wrfull = 1'b1;
    stray_pend  = 1'b1;
    tick();
    tick();
    fifo_wrfull = 1'b0;
    exp_ovf     = 1'b1;
    chk("stray_ovf", 64'(overflow), 64'd1);
    chk("stray_idle", 64'(dbg_state), 64'(IDLE));
    start_frame(32'h0000_8000, 16);
    wait_done("t5b", 16, 2000);

    // reset in the middle of a frame
    start_frame(32'h5000_0000, 64);
    repeat (6) tick();
    reset = 1'b1;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_read", 64'(avm_read), 64'd0);
    chk("t6_addr", 64'(avm_address), 64'd0);
    chk("t6_bc", 64'(avm_burstcount), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_state", 64'(dbg_state), 64'(IDLE));
    rd_q.delete();
    exp_q.delete();
    exp_burst_q.delete();
    pend_model        = 0;
    last_ready        = 0;
    hold_chk          = 1'b0;
    burst_cnt         = 0;
    avm_readdatavalid = 1'b0;
    exp_ovf           = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    start_frame(32'h6000_0100, 20);
    wait_done("t6", 20, 2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
